// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage. It issues credit-limited requests to a variable-latency
// instruction memory, keeps returned words in an in-order buffer, and flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic            live;
  logic [31:0]     fetch_pc, rsp_pc;
  logic [CW-1:0]   outstanding, drop_cnt, count, out_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW:0]     credit;
  logic            req_fire, rsp_take, pop, misaligned;

  logic [31:0]     data_mem  [FIFO_DEPTH];
  logic [31:0]     pc_mem    [FIFO_DEPTH];
  logic            fault_mem [FIFO_DEPTH];

  logic            wr_en, wr_fault;
  logic [PW-1:0]   wr_idx;
  logic [31:0]     wr_data, wr_pc;

  // Both handshakes (imem_req and inst) transfer on any cycle where valid and
  // ready are high together; valid never depends on ready, and both valids are
  // pure functions of registered state.
  // live holds requests off for the first cycle after reset release, so reset
  // itself never presents a request.
  assign credit         = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = live && (state == RUN) && (credit < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_nxt    = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign rsp_take   = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_data  = inst_valid ? data_mem[rd_ptr]  : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign inst_fault = inst_valid ? fault_mem[rd_ptr] : 1'b0;

  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = misaligned ? HALT : RUN;
    else if (rsp_take && imem_rsp_err)
      state_nxt = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // A misaligned redirect leaves exactly one fault entry in slot 0 of the flushed buffer.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = wr_ptr;
    wr_data  = imem_rsp_data;
    wr_pc    = rsp_pc;
    wr_fault = imem_rsp_err;
    if (redirect_valid) begin
      if (misaligned) begin
        wr_en    = 1'b1;
        wr_idx   = '0;
        wr_data  = NOP;
        wr_pc    = redirect_pc;
        wr_fault = 1'b1;
      end
    end else if (rsp_take) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx]  <= wr_data;
      pc_mem[wr_idx]    <= wr_pc;
      fault_mem[wr_idx] <= wr_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live        <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      live        <= 1'b1;
      outstanding <= out_nxt;
      if (redirect_valid) begin
        // Everything still in flight, including this cycle's request, is old-path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= out_nxt;
        rd_ptr   <= '0;
        wr_ptr   <= misaligned ? PW'(1) : '0;
        count    <= misaligned ? CW'(1) : '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            rsp_pc <= rsp_pc + 32'd4;
            if (imem_rsp_err)
              drop_cnt <= out_nxt;
          end
        end
        wr_ptr <= wr_ptr + PW'(rsp_take);
        rd_ptr <= rd_ptr + PW'(pop);
        count  <= count + CW'(rsp_take) - CW'(pop);
      end
    end
  end

  // Credits cover buffer plus in-flight words, so a push never finds the buffer full.
  push_into_full: assert property (@(posedge clk) disable iff (rst)
    !(rsp_take && (count == CW'(FIFO_DEPTH))));

endmodule
